// File: rtl/data_pack.sv
// Packs 7-bit framed symbols four per 32-bit word; each byte lane is {lane_valid, symbol}.
// Optional idle flush of partial words is enabled with `define DATA_PACK_FLUSH_EN.
module data_pack #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        sop_in,
  input  logic        eop_in,
  input  logic [6:0]  data_in,
  output logic        ready_out,
  input  logic        ready_in,
  output logic        valid_out,
  output logic        sop_out,
  output logic        eop_out,
  output logic [31:0] data_out,
  output logic        err_out
);

  if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_timeout_range
    $error("data_pack: TIMEOUT must be in 1..255");
  end

  logic [23:0] acc_q, acc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        acc_sop_q, acc_sop_d;
  logic        valid_q, valid_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  logic        acc;
  logic        restart;
  logic [1:0]  base_cnt;
  logic [23:0] base_acc;
  logic        base_sop;
  logic [31:0] word;

`ifdef DATA_PACK_FLUSH_EN
  localparam logic [7:0] FlushAt = 8'(TIMEOUT - 1);
  logic [7:0] idle_q, idle_d;
`endif

  assign ready_out = !valid_q || ready_in;
  assign acc       = valid_in && ready_out;

  assign valid_out = valid_q;
  assign sop_out   = sop_q;
  assign eop_out   = eop_q;
  assign data_out  = data_q;
  assign err_out   = err_q;

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    acc_sop_d = acc_sop_q;
    valid_d   = valid_q && !ready_in;
    sop_d     = sop_q;
    eop_d     = eop_q;
    data_d    = data_q;
    err_d     = err_q;
`ifdef DATA_PACK_FLUSH_EN
    idle_d    = idle_q;
`endif

    // A sop arriving mid-word abandons the partial lanes and restarts at lane 0.
    restart  = sop_in && (cnt_q != 2'd0);
    base_cnt = restart ? 2'd0 : cnt_q;
    base_acc = restart ? 24'h0 : acc_q;
    base_sop = (base_cnt == 2'd0) ? sop_in : acc_sop_q;

    word = {8'h00, base_acc};
    case (base_cnt)
      2'd0: word[7:0]   = {1'b1, data_in};
      2'd1: word[15:8]  = {1'b1, data_in};
      2'd2: word[23:16] = {1'b1, data_in};
      2'd3: word[31:24] = {1'b1, data_in};
    endcase

    if (acc) begin
      if (restart) err_d = 1'b1;
      if (base_cnt == 2'd3 || eop_in) begin
        valid_d   = 1'b1;
        data_d    = word;
        sop_d     = base_sop;
        eop_d     = eop_in;
        acc_d     = 24'h0;
        cnt_d     = 2'd0;
        acc_sop_d = 1'b0;
      end else begin
        acc_d     = word[23:0];
        cnt_d     = base_cnt + 2'd1;
        acc_sop_d = base_sop;
      end
`ifdef DATA_PACK_FLUSH_EN
      idle_d = 8'h00;
`endif
    end
`ifdef DATA_PACK_FLUSH_EN
    else if (cnt_q != 2'd0) begin
      // idle_q counts earlier idle cycles, so this cycle is the TIMEOUT-th one.
      if (idle_q >= FlushAt && ready_out) begin
        valid_d   = 1'b1;
        data_d    = {8'h00, acc_q};
        sop_d     = acc_sop_q;
        eop_d     = 1'b0;
        acc_d     = 24'h0;
        cnt_d     = 2'd0;
        acc_sop_d = 1'b0;
        idle_d    = 8'h00;
      end else if (idle_q != 8'hff) begin
        idle_d = idle_q + 8'h01;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q     <= 24'h0;
      cnt_q     <= 2'd0;
      acc_sop_q <= 1'b0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      data_q    <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      acc_sop_q <= acc_sop_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

`ifdef DATA_PACK_FLUSH_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle_q <= 8'h00;
    else      idle_q <= idle_d;
  end
`endif

endmodule

// File: tb/tb_data_pack.sv
// Randomised scoreboard bench for data_pack with a queue-based packing model.
module tb_data_pack;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0, sop_in = 1'b0, eop_in = 1'b0;
  logic [6:0]  data_in = 7'h0;
  logic        ready_out;
  logic        ready_in = 1'b1;
  logic        valid_out, sop_out, eop_out, err_out;
  logic [31:0] data_out;

  data_pack #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .sop_in    (sop_in),
    .eop_in    (eop_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .sop_out   (sop_out),
    .eop_out   (eop_out),
    .data_out  (data_out),
    .err_out   (err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] got_data[$];
  logic        got_sop[$];
  logic        got_eop[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state: symbols of the word being built.
  logic [6:0] part[$];
  logic       part_sop = 1'b0;
  int         idle_cnt = 0;
  logic       err_exp = 1'b0;

  logic        held = 1'b0;
  logic [31:0] h_data;
  logic        h_sop, h_eop;

  bit rdy_rand = 1'b0;
  bit rdy_val  = 1'b1;
  int last_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic emit(input logic e);
    exp_t x;
    x.data = 32'h0;
    foreach (part[i]) x.data[8*i +: 8] = {1'b1, part[i]};
    x.sop = part_sop;
    x.eop = e;
    x.cyc = cyc;
    sb.push_back(x);
    part.delete();
  endtask

  always @(posedge clk) begin
    #2;
    ready_in = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
  end

  // Monitor first, then model update, so both see the same pre-edge view.
  always @(negedge clk) begin
    if (rst) begin
      chk("ready_out", 32'(ready_out), 32'(!valid_out || ready_in));
      chk("err_out", 32'(err_out), 32'(err_exp));
      if (valid_out) begin
        if (held) begin
          chk("hold_data", data_out, h_data);
          chk("hold_sop", 32'(sop_out), 32'(h_sop));
          chk("hold_eop", 32'(eop_out), 32'(h_eop));
        end else if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h expected none", data_out);
        end else begin
          chk("word_data", data_out, sb[0].data);
          chk("word_sop", 32'(sop_out), 32'(sb[0].sop));
          chk("word_eop", 32'(eop_out), 32'(sb[0].eop));
          chk("latency", 32'(cyc), 32'(sb[0].cyc + 1));
        end
        if (ready_in) begin
          if (!held && sb.size() != 0) void'(sb.pop_front());
          got_data.push_back(data_out);
          got_sop.push_back(sop_out);
          got_eop.push_back(eop_out);
          held = 1'b0;
        end else begin
          if (!held && sb.size() != 0) void'(sb.pop_front());
          held   = 1'b1;
          h_data = data_out;
          h_sop  = sop_out;
          h_eop  = eop_out;
        end
      end

      if (valid_in && ready_out) begin
        if (sop_in && part.size() != 0) begin
          err_exp = 1'b1;
          part.delete();
        end
        if (part.size() == 0) part_sop = sop_in;
        part.push_back(data_in);
        if (part.size() == 4 || eop_in) emit(eop_in);
        idle_cnt = 0;
      end
`ifdef DATA_PACK_FLUSH_EN
      else if (part.size() != 0) begin
        idle_cnt++;
        if (idle_cnt >= int'(TO) && ready_out) begin
          emit(1'b0);
          idle_cnt = 0;
        end
      end
`endif
      cyc++;
    end
  end

  task automatic send(input logic [6:0] d, input logic s, input logic e);
    bit ok;
    int n;
    valid_in = 1'b1;
    data_in  = d;
    sop_in   = s;
    eop_in   = e;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 1000) begin
      @(negedge clk);
      ok = ready_out;
      n++;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 1000 cycles");
    end
    last_wait = n;
    valid_in  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_got(input string name, input int idx, input logic [31:0] d,
                           input logic s, input logic e);
    if (idx >= got_data.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: got no word expected %h", name, d);
    end else begin
      chk({name, "_data"}, got_data[idx], d);
      chk({name, "_sop"}, 32'(got_sop[idx]), 32'(s));
      chk({name, "_eop"}, 32'(got_eop[idx]), 32'(e));
    end
  endtask

  initial begin
    int b;
    int stalls;
    #3;
    chk("rst_ready_out", 32'(ready_out), 32'd1);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_sop_out", 32'(sop_out), 32'd0);
    chk("rst_eop_out", 32'(eop_out), 32'd0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_err_out", 32'(err_out), 32'd0);
    idle(2);
    rst = 1'b1;
    idle(1);

    // Eight symbols, two full words, no backpressure.
    b = got_data.size();
    stalls = 0;
    for (int i = 1; i <= 8; i++) begin
      send(7'(i), i == 1, i == 8);
      if (last_wait != 1) stalls++;
    end
    idle(3);
    chk("no_stall", 32'(stalls), 32'd0);
    check_got("w8_0", b, 32'h84838281, 1'b1, 1'b0);
    check_got("w8_1", b + 1, 32'h88878685, 1'b0, 1'b1);

    // Five-symbol packet leaves a one-lane tail.
    b = got_data.size();
    for (int i = 0; i < 5; i++) send(7'(8'h10 + i), i == 0, i == 4);
    idle(3);
    check_got("w5_1", b + 1, 32'h00000094, 1'b0, 1'b1);

    b = got_data.size();
    send(7'h7f, 1'b1, 1'b1);
    idle(3);
    check_got("single", b, 32'h000000ff, 1'b1, 1'b1);

    // Backpressure: a full word waits while downstream stalls.
    b = got_data.size();
    rdy_val = 1'b0;
    idle(1);
    for (int i = 0; i < 4; i++) send(7'(8'h30 + i), i == 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_ready_out", 32'(ready_out), 32'd0);
      chk("bp_data_out", data_out, 32'hb3b2b1b0);
    end
    @(posedge clk);
    #1;
    rdy_val = 1'b1;
    send(7'h34, 1'b0, 1'b0);
    send(7'h35, 1'b0, 1'b1);
    idle(3);
    check_got("bp_0", b, 32'hb3b2b1b0, 1'b1, 1'b0);
    check_got("bp_1", b + 1, 32'h0000b5b4, 1'b0, 1'b1);

    // Missing eop: sop on the third symbol discards the first two.
    b = got_data.size();
    send(7'h41, 1'b1, 1'b0);
    send(7'h42, 1'b0, 1'b0);
    send(7'h43, 1'b1, 1'b0);
    send(7'h44, 1'b0, 1'b1);
    idle(3);
    chk("err_set", 32'(err_out), 32'd1);
    check_got("err_word", b, 32'h0000c4c3, 1'b1, 1'b1);
    chk("err_word_count", 32'(got_data.size() - b), 32'd1);

`ifdef DATA_PACK_FLUSH_EN
    b = got_data.size();
    send(7'h21, 1'b1, 1'b0);
    send(7'h22, 1'b0, 1'b0);
    idle(8);
    check_got("flush", b, 32'h0000a2a1, 1'b1, 1'b0);
`endif

    // Random traffic with random backpressure and idle gaps.
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(7'($urandom_range(0, 127)), $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
    end
    send(7'h55, 1'b0, 1'b1);
    rdy_rand = 1'b0;
    rdy_val  = 1'b1;
    idle(10);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("err_sticky", 32'(err_out), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_pack.md
# data_pack

Upstream neighbour of `data_unpack`: accepts a stream of 7-bit symbols with packet framing and packs them four per 32-bit word for the unpack stage. Each byte lane carries one symbol plus a lane-valid flag, so short final words need no side-band count. Valid/ready handshakes are used on both sides, and a single output holding register absorbs downstream backpressure.

## Interface
- `TIMEOUT`, default 16: idle cycles before a partial word is flushed. Used only with `DATA_PACK_FLUSH_EN`; legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `valid_in` in 1: `data_in`, `sop_in` and `eop_in` are valid.
- `sop_in` in 1: the symbol is the first of a packet.
- `eop_in` in 1: the symbol is the last of a packet.
- `data_in` in 7: input symbol.
- `ready_out` out 1: the block accepts a symbol this cycle.
- `ready_in` in 1: downstream accepts a word this cycle.
- `valid_out` out 1: the output word is valid.
- `sop_out` out 1: the word holds the packet's first symbol in lane 0.
- `eop_out` out 1: the word holds the packet's last symbol.
- `data_out` out 32: packed word. Lane k is `data_out[8k+7:8k]` and equals {lane_valid, symbol}.
- `err_out` out 1: sticky framing-error flag, cleared only by reset.

## Operation
- Symbol accept: `acc = valid_in && ready_out`.
- Ready: `ready_out = !valid_out || ready_in`. This is combinational, with no bubble when the word drains in the same cycle.
- State:
  - accumulator `acc_q[23:0]` holds lanes 0..2;
  - lane counter `cnt` (0..3);
  - `acc_sop` flag;
  - output register.
- Lane fill order: lane 0 first, in bits [7:0].
- Accepted symbol with `cnt<3` and `!eop_in`:
  - write {1'b1, `data_in`} into lane `cnt`;
  - increment `cnt`;
  - `acc_sop` is set if `sop_in` arrives at `cnt==0`.
- Accepted symbol with `cnt==3` or `eop_in`:
  - load the output register with the accumulated lanes plus this symbol in lane `cnt`;
  - unused higher lanes are 8'h00;
  - `valid_out=1`, `sop_out=acc_sop` (or `sop_in` if `cnt==0`), `eop_out=eop_in`;
  - clear the accumulator and set `cnt=0`.
- `sop_in` with `cnt!=0` (missing eop):
  - discard the partial lanes and set `err_out`;
  - the symbol starts a new word at lane 0 with `sop` set.
- `sop_in && eop_in` on one symbol: emits a one-lane word with `sop_out=eop_out=1`.
- Output hold: `data_out`, `sop_out` and `eop_out` are stable while `valid_out && !ready_in`. `valid_out` clears on `ready_in` unless a new word loads in the same cycle.
- `valid_in` low: no state change; the accumulator holds.

## Timing
- Latency: a word is presented on `valid_out` in the cycle after its completing symbol is accepted (1 cycle).
- Throughput: one symbol per cycle, i.e. one word per four cycles, with no bubbles while `ready_in=1`.
- Reset (`rst` low, async):
  - `valid_out=0`, `sop_out=0`, `eop_out=0`, `data_out=0`, `err_out=0`;
  - `cnt=0`, accumulator 0, flush counter 0.
  - `ready_out` is 1 during reset.
- Reset mid-packet drops the partial word and any undelivered output word. There is no recovery state.
- Completing symbol while the output is full and `ready_in=0`: impossible, because `ready_out` is 0.

## Configuration
- Macro `DATA_PACK_FLUSH_EN`.
- Defined:
  - an 8-bit idle counter increments each cycle with `cnt!=0 && !acc`, and resets on any accept;
  - on reaching `TIMEOUT` with the output register free, the partial word is emitted with `eop_out=0`, `sop_out=acc_sop`, lane flags marking the filled lanes, and `cnt=0`;
  - if the output register is busy, the flush waits.
- Undefined: there is no counter, and a partial word waits indefinitely for further symbols or eop.

## Test plan
- Reset release, then 8 symbols 7'h01..7'h08 with sop on the first and eop on the last, `ready_in=1`:
  - word 32'h84838281 with sop=1, eop=0;
  - then 32'h88878685 with sop=0, eop=1;
  - each word 1 cycle after its 4th symbol;
  - `ready_out` constantly 1.
- 5-symbol packet 7'h10..7'h14 (eop on the 5th): second word is 32'h00000094, eop=1.
- Single symbol 7'h7F with sop=eop=1: word 32'h000000FF, sop=eop=1.
- `ready_in=0` for 10 cycles while a word is pending:
  - `ready_out=0`;
  - `data_out` is held;
  - no symbol is lost once `ready_in` returns to 1.
- Two symbols, then `sop_in` on the third symbol:
  - `err_out` goes to 1 and stays 1;
  - the first two symbols never appear;
  - the new packet packs from lane 0.
- With `DATA_PACK_FLUSH_EN` and `TIMEOUT=4`: two symbols 7'h21, 7'h22 (sop on the first), then idle:
  - word 32'h0000A2A1, sop=1, eop=0, 4 idle cycles after the last accept.
